// File: rtl/sha256_msg_schedule.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sha256_msg_schedule: streams SHA-256 schedule words W[0..NUM_WORDS-1] of a
// 512-bit block through a valid/ready handshake.      Revision: 1.0
// ----------------------------------------------------------------------------
module sha256_msg_schedule #(
  parameter int NUM_WORDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [511:0] block_in,
  input  logic         w_ready,
  output logic         w_valid,
  output logic [31:0]  w_out,
  output logic [5:0]   w_index,
  output logic         busy,
  output logic         done
);

  localparam logic [5:0] c_LAST_IDX = 6'(NUM_WORDS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [5:0]  idx_q, idx_d;
  logic        done_q, done_d;
  logic [31:0] w_new;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // W[t+16] from the window holding W[t..t+15]
  assign w_new = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          for (int i = 0; i < 16; i++) begin
            win_d[i] = block_in[511 - 32*i -: 32];
          end
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (w_ready) begin
          // Final word: window and index are left as-is so outputs hold in IDLE
          if (idx_q == c_LAST_IDX) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            for (int i = 0; i < 15; i++) begin
              win_d[i] = win_q[i+1];
            end
            win_d[15] = w_new;
            idx_d     = idx_q + 6'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      win_q   <= win_d;
    end
  end

  assign w_valid = (state_q == S_RUN);
  assign busy    = (state_q == S_RUN);
  assign w_out   = win_q[0];
  assign w_index = idx_q;
  assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_schedule.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sha256_msg_schedule: scoreboard bench for the SHA-256 message schedule.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_sha256_msg_schedule;

  logic         clk;
  logic         rst;
  logic         load;
  logic [511:0] block_in;
  logic         w_ready;
  logic         w_valid;
  logic [31:0]  w_out;
  logic [5:0]   w_index;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        abc;
    logic [5:0]  idx;
    logic [31:0] w;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model_w [64];
  logic        prev_done = 1'b0;

  localparam logic [511:0] c_ABC  = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] c_ZERO = 512'h0;
  localparam logic [511:0] c_JUNK = {16{32'hDEADBEEF}};

  sha256_msg_schedule #(.NUM_WORDS(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .block_in (block_in),
    .w_ready  (w_ready),
    .w_valid  (w_valid),
    .w_out    (w_out),
    .w_index  (w_index),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] m_sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] m_sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Published values of the "abc" schedule, checked independently of the model
  function automatic bit abc_ref(input logic [5:0] idx, output logic [31:0] v);
    v = '0;
    abc_ref = 1'b1;
    case (idx)
      6'd0:    v = 32'h61626380;
      6'd15:   v = 32'h00000018;
      6'd16:   v = 32'h61626380;
      6'd17:   v = 32'h000F0000;
      6'd18:   v = 32'h7DA86405;
      6'd63:   v = 32'h12B1EDEB;
      default: abc_ref = 1'b0;
    endcase
  endfunction

  task automatic push_block(input logic [511:0] blk, input bit is_abc);
    for (int t = 0; t < 16; t++) begin
      model_w[t] = blk[511 - 32*t -: 32];
    end
    for (int t = 16; t < 64; t++) begin
      model_w[t] = m_sig1(model_w[t-2]) + model_w[t-7] + m_sig0(model_w[t-15]) + model_w[t-16];
    end
    for (int t = 0; t < 64; t++) begin
      sb.push_back({is_abc, 6'(t), model_w[t]});
    end
  endtask

  task automatic start_load(input logic [511:0] blk, input bit is_abc);
    push_block(blk, is_abc);
    block_in = blk;
    load     = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  // mode: 0 plain, 1 stall at W20, 2 stray load at W30, 3 reset at W40,
  //       4 back-to-back zero-block load in the done cycle
  task automatic wait_done(input int exp_cycles, input int mode, input string name);
    int n;
    bit seen;
    bit stalled;
    bit junk_pending;
    n = 0;
    seen = 0;
    stalled = 0;
    junk_pending = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (junk_pending) begin
        load = 1'b0;
        block_in = c_ZERO;
        junk_pending = 0;
      end
      if (n == 1) begin
        chk({name, "_first_valid"}, 64'(w_valid), 64'd1);
        chk({name, "_first_index"}, 64'(w_index), 64'd0);
      end
      if (done) begin
        seen = 1;
        break;
      end
      if (mode == 1 && !stalled && w_valid && w_index == 6'd19) begin
        stalled = 1;
        @(posedge clk);
        #1 w_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          n++;
          chk("stall_index", 64'(w_index), 64'd20);
          chk("stall_word", 64'(w_out), 64'(model_w[20]));
        end
        @(posedge clk);
        #1 w_ready = 1'b1;
      end
      if (mode == 2 && w_valid && w_index == 6'd30 && !junk_pending) begin
        load = 1'b1;
        block_in = c_JUNK;
        junk_pending = 1;
      end
      if (mode == 3 && w_valid && w_index == 6'd40) begin
        #1 rst = 1'b1;
        #1;
        chk("rst_w_valid", 64'(w_valid), 64'd0);
        chk("rst_w_out", 64'(w_out), 64'd0);
        chk("rst_w_index", 64'(w_index), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_done", 64'(done), 64'd0);
        chk("post_rst_valid", 64'(w_valid), 64'd0);
        sb.delete();
        return;
      end
      if (mode == 4 && w_valid && w_index == 6'd63) begin
        @(posedge clk);
        #1;
        push_block(c_ZERO, 1'b0);
        block_in = c_ZERO;
        load = 1'b1;
      end
    end
    chk({name, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      chk({name, "_done_latency"}, 64'(n), 64'(exp_cycles));
      chk({name, "_done_busy"}, 64'(busy), 64'd0);
      chk({name, "_done_valid"}, 64'(w_valid), 64'd0);
    end
    if (mode == 4) begin
      @(posedge clk);
      #1 load = 1'b0;
    end
  endtask

  // Monitor: a transfer is decided by w_valid & w_ready seen half a cycle early
  initial begin
    exp_t        e;
    logic [31:0] v;
    forever begin
      @(negedge clk);
      if (!rst && w_valid && w_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("w_index", 64'(w_index), 64'(e.idx));
          chk("w_out", 64'(w_out), 64'(e.w));
          if (e.abc && abc_ref(e.idx, v)) begin
            chk("abc_const", 64'(w_out), 64'(v));
          end
        end
      end
      if (done) begin
        chk("done_single_pulse", 64'(prev_done), 64'd0);
      end
      prev_done = done;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    w_ready  = 1'b1;
    block_in = c_ZERO;
    #3;
    chk("init_w_valid", 64'(w_valid), 64'd0);
    chk("init_w_out", 64'(w_out), 64'd0);
    chk("init_w_index", 64'(w_index), 64'd0);
    chk("init_busy", 64'(busy), 64'd0);
    chk("init_done", 64'(done), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    start_load(c_ABC, 1'b1);
    wait_done(65, 0, "abc");
    repeat (2) @(negedge clk);

    start_load(c_ZERO, 1'b0);
    wait_done(65, 0, "zero");
    repeat (2) @(negedge clk);

    start_load(c_ABC, 1'b1);
    wait_done(70, 1, "stall");
    repeat (2) @(negedge clk);

    start_load(c_ABC, 1'b1);
    wait_done(65, 2, "stray_load");
    repeat (2) @(negedge clk);

    start_load(c_ABC, 1'b1);
    wait_done(65, 3, "reset_mid");
    repeat (2) @(negedge clk);
    start_load(c_ABC, 1'b1);
    wait_done(65, 0, "after_rst");
    repeat (2) @(negedge clk);

    start_load(c_ABC, 1'b1);
    wait_done(65, 4, "b2b_first");
    wait_done(65, 0, "b2b_second");

    repeat (4) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sha256_msg_schedule.md
SHA256_MSG_SCHEDULE -- requirements
Module: sha256_msg_schedule

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 64, the number of schedule words emitted per block (legal range 16..64).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port load  input  1  a block-load request, sampled only in IDLE.
REQ-005 SHALL have port block_in  input  512  the padded message block; word 0 is block_in[511:480], word 15 is block_in[31:0].
REQ-006 SHALL have port w_ready  input  1  consumer (round engine) accepts w_out this cycle.
REQ-007 SHALL have port w_valid  output  1  w_out and w_index hold a valid schedule word.
REQ-008 SHALL have port w_out  output  32  the current schedule word W[t].
REQ-009 SHALL have port w_index  output  6  t, the index of w_out.
REQ-010 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-011 SHALL have port done  output  1  a one-cycle pulse after the last word is accepted.

Function
REQ-012 SHALL implement two states: IDLE and RUN.
REQ-013 In IDLE with load=1, SHALL capture block_in into a 16-word window win[0..15] (win[0]=word 0), set w_index=0, and enter RUN on the next edge.
REQ-014 In RUN, SHALL drive w_valid=1, w_out=win[0], and busy=1. First valid word is one cycle after load (latency 1).
REQ-015 A transfer SHALL occur on any edge with w_valid=1 and w_ready=1; w_out and w_index SHALL hold stable while w_ready=0.
REQ-016 On each transfer, SHALL shift win[i]<=win[i+1] for i=0..14 and set win[15]<=new, where new is computed as follows.
- new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0], mod 2^32, with carries discarded.
- This yields W[t+16].
REQ-017 sig0(x) SHALL equal rotr(x,7) ^ rotr(x,18) ^ (x>>3); sig1(x) SHALL equal rotr(x,17) ^ rotr(x,19) ^ (x>>10). Both are logical right shifts.
REQ-018 On each transfer, SHALL increment w_index by 1.
REQ-019 On the transfer with w_index=NUM_WORDS-1, SHALL return to IDLE, pulse done=1 for exactly the next cycle, and deassert w_valid.
REQ-020 SHALL ignore load while in RUN; the window is not disturbed. load and done in the same cycle SHALL start a new block (done is asserted in IDLE).
REQ-021 In IDLE, w_valid SHALL be 0. w_out and w_index SHALL retain their last values and are don't-care to consumers.
REQ-022 SHALL need no more than one 4-input 32-bit adder per cycle; no multicycle paths.

Reset
REQ-023 While rst=1, the block SHALL be in IDLE, independent of clk.
REQ-024 While rst=1, window SHALL be all-zero, and w_valid, w_out, w_index, busy, and done SHALL all be 0.
REQ-025 Reset asserted mid-RUN SHALL abort the block with no done pulse. After release, the block SHALL wait in IDLE for a fresh load.

Verification
REQ-026 "abc" padded block (0x61626380, then 14 zero words, then 0x00000018), w_ready=1 -> required response:
- W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W63=0x12B1EDEB.
- done asserts exactly 65 cycles after load.
REQ-027 All-zero block, w_ready=1 -> all 64 words 0x00000000; w_index counts 0..63; a single done pulse.
REQ-028 "abc" block with w_ready held 0 for 5 cycles at w_index=20 -> w_out and w_index frozen at 20 for those cycles. The word sequence SHALL be identical to REQ-026.
REQ-029 load pulsed with a different block_in at w_index=30 -> ignored; the output sequence SHALL be identical to REQ-026.
REQ-030 rst asserted at w_index=40 -> required response:
- Outputs zero asynchronously, with no done pulse.
- After release, a new "abc" load SHALL reproduce REQ-026 from W0.
REQ-031 A second load in the same cycle as done -> the second block's W0 appears on the following cycle; no idle gap beyond one cycle.
